// File: rtl/bht_ctrl.sv
// Write-port sequencer for the branch history table: clears the table after reset or flush,
// then drains queued branch-resolve updates as read-modify-write with write forwarding.
module bht_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned IDX_W      = 10,
    parameter int unsigned QDEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_req,
    input  logic                  upd_valid,
    input  logic [DATA_WIDTH-1:0] upd_pc,
    input  logic                  upd_correct,
    output logic                  upd_ready,
    output logic [IDX_W-1:0]      tbl_ridx,
    input  logic [1:0]            tbl_rdata,
    output logic                  tbl_we,
    output logic [IDX_W-1:0]      tbl_widx,
    output logic [1:0]            tbl_wdata,
    output logic                  busy,
    output logic [31:0]           cnt_correct,
    output logic [31:0]           cnt_error,
    output logic [31:0]           cnt_drop
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(QDEPTH);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;

    logic [IDX_W-1:0] fifo_idx_q [QDEPTH];
    logic             fifo_cor_q [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [IDX_W-1:0] last_head_q;

    logic             we_d;
    logic [IDX_W-1:0] widx_d;
    logic [1:0]       wdata_d;

    logic             empty;
    logic             push;
    logic             push_store;
    logic             drop;
    logic             pop;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] head_idx;
    logic             head_cor;
    logic [1:0]       cur;

    // Only the word-index bits of the PC select a table entry.
    logic unused_pc;
    assign unused_pc = ^{upd_pc[DATA_WIDTH-1:IDX_W+2], upd_pc[1:0]};

    assign upd_idx    = upd_pc[IDX_W+1:2];
    assign empty      = (count_q == '0);
    assign upd_ready  = (count_q != FULL_CNT);
    assign push       = upd_valid & upd_ready;
    assign drop       = upd_valid & ~upd_ready;
    assign push_store = push & ~flush_req;
    assign pop        = (state_q == StRun) & ~empty & ~flush_req;
    assign busy       = (state_q == StInit);

    assign head_idx = fifo_idx_q[rd_ptr_q];
    assign head_cor = fifo_cor_q[rd_ptr_q];
    assign tbl_ridx = empty ? last_head_q : head_idx;

    // The table has not absorbed the write currently on the bus, so bypass it.
    assign cur = (tbl_we && (tbl_widx == head_idx)) ? tbl_wdata : tbl_rdata;

    function automatic logic [1:0] next_ctr(input logic [1:0] val, input logic inc);
        logic [1:0] res;
        if (inc) begin
            res = (val == 2'b11) ? 2'b11 : val + 2'b01;
        end else begin
            res = (val == 2'b00) ? 2'b00 : val - 2'b01;
        end
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        we_d    = 1'b0;
        widx_d  = tbl_widx;
        wdata_d = tbl_wdata;
        if (flush_req) begin
            state_d = StInit;
            sweep_d = '0;
        end else begin
            unique case (state_q)
                StInit: begin
                    we_d    = 1'b1;
                    widx_d  = sweep_q;
                    wdata_d = 2'b01;
                    if (sweep_q == LAST_IDX) begin
                        state_d = StRun;
                        sweep_d = '0;
                    end else begin
                        sweep_d = sweep_q + 1'b1;
                    end
                end
                StRun: begin
                    if (!empty) begin
                        we_d    = 1'b1;
                        widx_d  = head_idx;
                        wdata_d = next_ctr(cur, head_cor);
                    end
                end
                default: state_d = StInit;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_req) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_store) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push_store, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StInit;
            sweep_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_head_q <= '0;
            tbl_we      <= 1'b0;
            tbl_widx    <= '0;
            tbl_wdata   <= 2'b00;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tbl_we    <= we_d;
            tbl_widx  <= widx_d;
            tbl_wdata <= wdata_d;
            if (!empty) begin
                last_head_q <= head_idx;
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_store) begin
            fifo_idx_q[wr_ptr_q] <= upd_idx;
            fifo_cor_q[wr_ptr_q] <= upd_correct;
        end
    end

    // Pushes coinciding with a flush are discarded but still counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_correct <= '0;
            cnt_error   <= '0;
            cnt_drop    <= '0;
        end else begin
            if (push && upd_correct) begin
                cnt_correct <= cnt_correct + 32'd1;
            end
            if (push && !upd_correct) begin
                cnt_error <= cnt_error + 32'd1;
            end
            if (drop) begin
                cnt_drop <= cnt_drop + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_bht_ctrl.sv
// Self-checking bench for bht_ctrl (DEPTH=16, QDEPTH=4): a transaction-level model with a
// logical counter table is compared every cycle, plus directed literal expectations.
module tb_bht_ctrl;

    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int IW = 4;
    localparam int QD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_req = 1'b0;
    logic          upd_valid = 1'b0;
    logic [DW-1:0] upd_pc = '0;
    logic          upd_correct = 1'b0;
    logic          upd_ready;
    logic [IW-1:0] tbl_ridx;
    logic [1:0]    tbl_rdata;
    logic          tbl_we;
    logic [IW-1:0] tbl_widx;
    logic [1:0]    tbl_wdata;
    logic          busy;
    logic [31:0]   cnt_correct, cnt_error, cnt_drop;

    bht_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .IDX_W      (IW),
        .QDEPTH     (QD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_req   (flush_req),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_correct (upd_correct),
        .upd_ready   (upd_ready),
        .tbl_ridx    (tbl_ridx),
        .tbl_rdata   (tbl_rdata),
        .tbl_we      (tbl_we),
        .tbl_widx    (tbl_widx),
        .tbl_wdata   (tbl_wdata),
        .busy        (busy),
        .cnt_correct (cnt_correct),
        .cnt_error   (cnt_error),
        .cnt_drop    (cnt_drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Physical table the DUT reads and writes.
    logic [1:0] mem [DEPTH];
    assign tbl_rdata = mem[tbl_ridx];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 2'b00;
        forever begin
            @(posedge clk);
            if (tbl_we === 1'b1) mem[tbl_widx] <= tbl_wdata;
        end
    end

    // Every write seen on the bus, encoded as idx*4 + data.
    int wlog[$];
    initial forever begin
        @(negedge clk);
        if (tbl_we === 1'b1) wlog.push_back(int'(tbl_widx) * 4 + int'(tbl_wdata));
    end

    // Behavioural model: a logical table of saturating counters and a FIFO of pending updates.
    typedef struct {
        int idx;
        bit cor;
    } upd_t;

    upd_t        mq[$];
    upd_t        m_e;
    int          m_tbl [DEPTH];
    int          m_we = 0, m_widx = 0, m_wdata = 0, m_busy = 1, m_sweep = 0, m_val = 0;
    bit          m_ready_pre = 1'b1;
    int unsigned m_cc = 0, m_ce = 0, m_cd = 0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (rst !== 1'b1) begin
            mq.delete();
            m_we = 0; m_widx = 0; m_wdata = 0; m_busy = 1; m_sweep = 0;
            m_cc = 0; m_ce = 0; m_cd = 0;
        end else begin
            m_ready_pre = (mq.size() < QD);
            if (upd_valid) begin
                if (!m_ready_pre) m_cd++;
                else if (upd_correct) m_cc++;
                else m_ce++;
            end
            m_e.idx = int'((upd_pc >> 2) % DEPTH);
            m_e.cor = upd_correct;
            if (flush_req) begin
                mq.delete();
                m_busy = 1; m_sweep = 0; m_we = 0;
            end else if (m_busy == 1) begin
                m_we = 1; m_widx = m_sweep; m_wdata = 1;
                m_tbl[m_sweep] = 1;
                if (m_sweep == DEPTH - 1) begin
                    m_busy = 0; m_sweep = 0;
                end else begin
                    m_sweep++;
                end
                if (upd_valid && m_ready_pre) mq.push_back(m_e);
            end else begin
                if (mq.size() > 0) begin
                    m_val = m_tbl[mq[0].idx];
                    m_val = mq[0].cor ? ((m_val == 3) ? 3 : m_val + 1)
                                      : ((m_val == 0) ? 0 : m_val - 1);
                    m_tbl[mq[0].idx] = m_val;
                    m_we = 1; m_widx = mq[0].idx; m_wdata = m_val;
                    void'(mq.pop_front());
                end else begin
                    m_we = 0;
                end
                if (upd_valid && m_ready_pre) mq.push_back(m_e);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("tbl_we", 64'(tbl_we), 64'(m_we));
        check("tbl_widx", 64'(tbl_widx), 64'(m_widx));
        check("tbl_wdata", 64'(tbl_wdata), 64'(m_wdata));
        check("busy", 64'(busy), 64'(m_busy));
        check("upd_ready", 64'(upd_ready), 64'(mq.size() < QD));
        check("cnt_correct", 64'(cnt_correct), 64'(m_cc));
        check("cnt_error", 64'(cnt_error), 64'(m_ce));
        check("cnt_drop", 64'(cnt_drop), 64'(m_cd));
        if (mq.size() > 0) check("tbl_ridx", 64'(tbl_ridx), 64'(mq[0].idx));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int pc, input bit cor);
        upd_valid   = v;
        upd_pc      = DW'(pc);
        upd_correct = cor;
    endtask

    int pcs [5] = '{32'h30, 32'h34, 32'h38, 32'h3c, 32'h40};
    bit cors [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int exp_drain [4] = '{12 * 4 + 2, 13 * 4 + 0, 14 * 4 + 2, 15 * 4 + 2};

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        check("rst busy", 64'(busy), 64'd1);
        check("rst ready", 64'(upd_ready), 64'd1);
        check("rst we", 64'(tbl_we), 64'd0);
        check("rst widx", 64'(tbl_widx), 64'd0);
        check("rst wdata", 64'(tbl_wdata), 64'd0);
        check("rst cnt", 64'(cnt_correct | cnt_error | cnt_drop), 64'd0);

        // Reset release: 16-entry sweep on consecutive cycles.
        rst = 1'b1;
        wlog.delete();
        repeat (16) tick();
        check("sweep busy", 64'(busy), 64'd0);
        check("sweep len", 64'(wlog.size()), 64'd16);
        for (int i = 0; i < 16; i++) check("sweep entry", 64'(wlog[i]), 64'(i * 4 + 1));
        tick();
        check("post sweep we", 64'(tbl_we), 64'd0);
        check("post sweep ready", 64'(upd_ready), 64'd1);

        // Single correct update to idx 4.
        drive(1, 32'h10, 1);
        tick();
        drive(0, 0, 0);
        tick();
        check("upd we", 64'(tbl_we), 64'd1);
        check("upd widx", 64'(tbl_widx), 64'd4);
        check("upd wdata", 64'(tbl_wdata), 64'd2);
        check("upd cnt_correct", 64'(cnt_correct), 64'd1);
        tick();

        // Two back-to-back mismatches to idx 4 need forwarding.
        drive(1, 32'h10, 0);
        tick();
        tick();
        drive(0, 0, 0);
        tick();
        check("fwd first", 64'(wlog[wlog.size() - 2]), 64'(4 * 4 + 1));
        check("fwd second", 64'(wlog[wlog.size() - 1]), 64'(4 * 4 + 0));

        // Saturation at both ends.
        drive(1, 32'h20, 1);
        repeat (3) tick();
        drive(0, 0, 0);
        tick();
        check("sat up 1", 64'(wlog[wlog.size() - 3]), 64'(8 * 4 + 2));
        check("sat up 2", 64'(wlog[wlog.size() - 2]), 64'(8 * 4 + 3));
        check("sat up 3", 64'(wlog[wlog.size() - 1]), 64'(8 * 4 + 3));
        drive(1, 32'h24, 0);
        repeat (2) tick();
        drive(0, 0, 0);
        tick();
        check("sat dn 1", 64'(wlog[wlog.size() - 2]), 64'(9 * 4 + 0));
        check("sat dn 2", 64'(wlog[wlog.size() - 1]), 64'(9 * 4 + 0));
        check("cnt after sat", 64'({cnt_correct, cnt_error}), {32'd4, 32'd4});

        // Overflow during the sweep: four accepted, fifth dropped.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        wlog.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1, pcs[i], cors[i]);
            if (i == 4) check("ovf ready", 64'(upd_ready), 64'd0);
            tick();
        end
        drive(0, 0, 0);
        repeat (15) tick();
        check("ovf log len", 64'(wlog.size()), 64'd20);
        for (int i = 0; i < 4; i++) check("ovf drain", 64'(wlog[16 + i]), 64'(exp_drain[i]));
        check("ovf cnt_drop", 64'(cnt_drop), 64'd1);

        // Flush in RUN with two updates queued at the end of a sweep.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (14) tick();
        drive(1, 32'h44, 1);
        tick();
        drive(1, 32'h48, 1);
        tick();
        drive(0, 0, 0);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check("flush busy", 64'(busy), 64'd1);
        check("flush we", 64'(tbl_we), 64'd0);
        wlog.delete();
        repeat (16) tick();
        tick();
        check("flush sweep len", 64'(wlog.size()), 64'd16);
        check("flush sweep first", 64'(wlog[0]), 64'd1);
        check("flush sweep last", 64'(wlog[15]), 64'(15 * 4 + 1));
        check("flush cnt_correct", 64'(cnt_correct), 64'd9);
        check("flush cnt_error", 64'(cnt_error), 64'd5);

        // Asynchronous reset in the middle of a sweep.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        #1;
        check("mid rst cnt_correct", 64'(cnt_correct), 64'd0);
        check("mid rst cnt_error", 64'(cnt_error), 64'd0);
        check("mid rst cnt_drop", 64'(cnt_drop), 64'd0);
        check("mid rst busy", 64'(busy), 64'd1);
        check("mid rst we", 64'(tbl_we), 64'd0);
        tick();
        rst = 1'b1;
        wlog.delete();
        tick();
        check("mid rst restart len", 64'(wlog.size()), 64'd1);
        check("mid rst restart idx", 64'(wlog[0]), 64'd1);
        repeat (17) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bht_ctrl.md
# bht_ctrl

Sequencing controller for the branch history table (BHT) of 2-bit saturating counters used by the IF-stage branch predictor. It owns the table's single write port. After reset or a flush request it clears the table one entry per cycle to weakly-not-taken (2'b01). Afterwards it queues MEM-stage resolve updates in a small FIFO and drains them one per cycle as read-modify-write operations with write forwarding. It also keeps correct/error/drop statistics for performance counters.

## Interface
- DATA_WIDTH, 32, PC width
- DEPTH, 1024, BHT entries (power of two)
- IDX_W, 10, log2(DEPTH)
- QDEPTH, 4, update FIFO entries (power of two, ≥2)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- flush_req  in  1  restart table clear; single-cycle pulse or level
- upd_valid  in  1  MEM-stage branch resolved this cycle
- upd_pc  in  DATA_WIDTH  PC of the resolved branch; index = upd_pc[IDX_W+1:2]
- upd_correct  in  1  1 = prediction matched outcome (counter increments); 0 = mismatch (counter decrements)
- upd_ready  out  1  FIFO not full
- tbl_ridx  out  IDX_W  combinational read index (FIFO head index)
- tbl_rdata  in  2  asynchronous table read data at tbl_ridx
- tbl_we  out  1  registered write enable
- tbl_widx  out  IDX_W  registered write index
- tbl_wdata  out  2  registered write data
- busy  out  1  table clear in progress; predictor must force not-taken
- cnt_correct  out  32  count of accepted updates with upd_correct=1
- cnt_error  out  32  count of accepted updates with upd_correct=0
- cnt_drop  out  32  count of updates presented while upd_ready=0

## Operation
- States: INIT (clear sweep) and RUN. busy = (state==INIT).
- Reset values:
  - state=INIT, sweep counter=0, FIFO empty.
  - tbl_we=0, tbl_widx=0, tbl_wdata=0.
  - all counters 0; busy=1; upd_ready=1.
- INIT, each cycle:
  - register tbl_we=1, tbl_widx=sweep counter, tbl_wdata=2'b01.
  - increment the sweep counter.
  - when the counter is DEPTH-1, go to RUN and wrap the counter to 0.
  - FIFO is not drained in INIT, but it still accepts pushes.
- RUN, FIFO non-empty:
  - pop the head and take cur = tbl_rdata.
  - forwarding: if tbl_we=1 and tbl_widx equals the head index, use cur = tbl_wdata instead.
  - register tbl_we=1, tbl_widx=head index, tbl_wdata=f(cur, correct).
  - correct: 00→01, 01→10, 10→11, 11→11.
  - mismatch: 00→00, 01→00, 10→01, 11→10.
- RUN, FIFO empty: register tbl_we=0; tbl_widx/tbl_wdata hold.
- Push: upd_valid & upd_ready stores {index, upd_correct} and increments cnt_correct or cnt_error.
- Drop: upd_valid & ~upd_ready discards the update and increments cnt_drop. Upstream never stalls.
- Simultaneous push and pop: both occur. upd_ready is evaluated from the pre-edge occupancy only, so a full FIFO rejects a push even when a pop happens the same cycle.
- flush_req (any state):
  - next state INIT, sweep counter 0, FIFO emptied.
  - a push in the same cycle is discarded, but still counted in cnt_correct or cnt_error.
  - no pop in that cycle; registered write is tbl_we=0.
  - counters are not cleared.
- Counters wrap at 2^32.
- rst mid-operation returns all state to reset values immediately.

## Timing
- Sweep:
  - first init write appears on the bus in the cycle after the first clk edge following rst release.
  - the DEPTH writes are on consecutive cycles.
  - busy falls on the same edge that registers the last init write (idx DEPTH-1).
- Update latency: accepted at edge E, popped at E+1 if it is at the head in RUN, write on the bus after E+1, table updated at E+2.
- Drain throughput: one update per cycle; back-to-back writes to the same index are correct through forwarding.
- tbl_ridx is valid whenever the FIFO is non-empty; otherwise it equals the last head index.

## Test plan
- Reset release with DEPTH=16:
  - 16 consecutive writes, idx 0..15, data 01.
  - busy deasserts on the edge registering idx 15; tbl_we=0 the following cycle; upd_ready=1.
- One update in RUN, upd_pc=0x10 (idx 4), correct, table entry 01:
  - write idx 4, data 10, on the bus two edges after acceptance.
  - cnt_correct=1.
- Forwarding, two consecutive mismatch updates to idx 4 starting from 10:
  - writes 01 then 00 on consecutive cycles, even though tbl_rdata still reads 10 for the second.
- Saturation:
  - correct update on an entry at 11 writes 11.
  - mismatch on an entry at 00 writes 00.
- Overflow, QDEPTH=4, five updates during INIT:
  - four accepted; fifth sees upd_ready=0; cnt_drop=1.
  - after INIT, four writes drain on consecutive cycles in FIFO order.
- Flush in RUN with 2 updates queued:
  - FIFO empties; busy=1; sweep restarts at idx 0.
  - the queued updates are never written; counters are retained.
- Reset mid-sweep:
  - counters read 0 and the sweep restarts at idx 0.
